// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage CPU.
// Drives PC / IF/ID enables, IF/ID squash and the ID/EX bubble mux.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_rn/id_rm(_used)  source registers of the ID instruction
//   ex_memread, ex_rd   load flag and destination of the EX instruction
//   br_taken            branch resolved taken this cycle
//   mem_busy            data memory stall; freezes the front end
//   pc_en, ifid_en      PC and IF/ID write enables
//   ifid_flush          IF/ID loads a NOP
//   idex_bubble         ID/EX control fields forced to zero
//   stall_cnt, flush_cnt, freeze_cnt  saturating performance counters
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the counters;
// otherwise the three counter ports are tied to zero.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    state_t     eff_state;
    logic [1:0] fcnt_q, fcnt_d;
    logic       lu;
    logic       lu_stall;

    // XZR reads as zero, so a load targeting it never creates a hazard.
    assign lu = ex_memread && (ex_rd != 5'd31) &&
                ((id_rn_used && (id_rn == ex_rd)) ||
                 (id_rm_used && (id_rm == ex_rd)));

    // Leaving FREEZE resumes whatever state was interrupted.
    assign eff_state = (state_q == FREEZE) ? ret_q : state_q;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        lu_stall    = 1'b0;
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        ret_d       = ret_q;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            state_d = FREEZE;
            if (state_q != FREEZE) begin
                ret_d = state_q;
            end
        end else if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                fcnt_d  = FCNT_INIT;
            end else begin
                state_d = RUN;
                fcnt_d  = 2'd0;
            end
        end else if (eff_state == FLUSH) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            // Saturating decrement keeps fcnt from ever wrapping.
            if (fcnt_q <= 2'd1) begin
                state_d = RUN;
                fcnt_d  = 2'd0;
            end else begin
                state_d = FLUSH;
                fcnt_d  = fcnt_q - 2'd1;
            end
        end else if (lu) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            lu_stall    = 1'b1;
            state_d     = RUN;
            fcnt_d      = 2'd0;
        end else begin
            state_d = RUN;
            fcnt_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q, freeze_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else begin
            if (lu_stall && !(&stall_q)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (ifid_flush && !(&flush_q)) begin
                flush_q <= flush_q + 1'b1;
            end
            if (mem_busy && !(&freeze_q)) begin
                freeze_q <= freeze_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign freeze_cnt = freeze_q;
`else
    logic unused_perf;
    assign unused_perf = lu_stall;
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
    assign freeze_cnt  = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage 64-bit pipelined CPU.
- Produces the enable, flush and bubble controls for the PC register, the IF/ID pipeline register and the ID/EX bubble mux.
- Detects load-use hazards and sequences multi-cycle squashes after taken branches.
- Freezes the front end while data memory is busy.
- Sits beside the decode stage; it consumes register fields from IF/ID and status from ID/EX, EX and the data memory.

## Interface
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is squashed per taken branch; legal 1..3.
- CNT_W, 32, width of each performance counter.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rn  in  5  first source register of instruction in ID.
- id_rm  in  5  second source register of instruction in ID.
- id_rn_used  in  1  ID instruction reads id_rn.
- id_rm_used  in  1  ID instruction reads id_rm.
- ex_memread  in  1  instruction in EX (ID/EX output) is a load.
- ex_rd  in  5  destination register of instruction in EX.
- br_taken  in  1  branch resolved taken this cycle; held stable by upstream while mem_busy=1.
- mem_busy  in  1  data memory not ready; whole front end must hold.
- pc_en  out  1  PC register write enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads a NOP (all-zero instruction) instead of the fetched word.
- idex_bubble  out  1  ID/EX control fields forced to zero.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  cycles with ifid_flush=1.
- freeze_cnt  out  CNT_W  cycles with mem_busy=1.

## Operation
- States: RUN, FLUSH, FREEZE.
  - Registered remaining-flush counter fcnt is 2 bits.
  - Registered ret_state records the state to resume after FREEZE.
- Load-use hazard is combinational:
  - lu = ex_memread & (ex_rd != 31) & ((id_rn_used & id_rn==ex_rd) | (id_rm_used & id_rm==ex_rd)).
  - Register 31 (XZR) never causes a hazard.
- Outputs are Mealy. Priority, highest first:
  1. rst=1: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1. Next state RUN, fcnt=0, ret_state=RUN.
  2. mem_busy=1 (any state): pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0.
     - Next state FREEZE.
     - ret_state is captured only when entering from RUN/FLUSH.
     - fcnt is held.
  3. br_taken=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1.
     - If FLUSH_CYCLES>1: next state FLUSH, fcnt=FLUSH_CYCLES-1. Otherwise next state RUN.
     - Overrides lu and restarts any in-progress flush.
  4. State FLUSH (or FREEZE with ret_state=FLUSH): pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1.
     - fcnt decrements.
     - Next state RUN when fcnt==1, else FLUSH.
  5. lu=1: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1. State stays RUN.
  6. Otherwise: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- Leaving FREEZE (mem_busy falls): that cycle is evaluated by rules 3-6 using ret_state as the current state.
- fcnt never wraps. It is 0 in RUN.

## Timing
- Control outputs are combinational from state and inputs, with zero-cycle latency to the pipeline registers' next edge.
- Load-use costs exactly one stall cycle.
  - The next cycle ex_memread reflects the bubble and lu clears, with no state needed.
- A taken branch squashes FLUSH_CYCLES consecutive fetches. mem_busy cycles inside the window pause it without consuming a count.
- Performance counters increment on the rising edge after a qualifying cycle, saturate at all-ones, and clear on rst.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt, flush_cnt and freeze_cnt are implemented as above.
- Not defined: the counter registers are omitted and the three ports are tied to 0. Control behaviour is identical.

## Test plan
- Reset: hold rst=1 two cycles with br_taken=1 → pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0 throughout; counters read 0 after release.
- Load-use: ex_memread=1, ex_rd=5, id_rn=5, id_rn_used=1 for one cycle → exactly one cycle pc_en=0, ifid_en=0, idex_bubble=1. With ex_rd=31, or with id_rn_used=0 → no stall.
- Branch, FLUSH_CYCLES=3: br_taken pulse → ifid_flush=1 for 3 consecutive cycles, pc_en=1 each, then normal; flush_cnt=3.
- Branch beats load-use: br_taken=1 and lu=1 in the same cycle → pc_en=1, ifid_flush=1; stall_cnt unchanged.
- Freeze mid-flush (FLUSH_CYCLES=3): mem_busy=1 for 4 cycles starting at the second flush cycle → all enables 0 for 4 cycles, then 2 more flush cycles; freeze_cnt=4, flush_cnt=3.
- Saturation (CNT_W=4, macro defined): 20 load-use cycles → stall_cnt=15. Without macro → all counters 0.
